// File: rtl/fx_exec_unit.sv
// fx_exec_unit: fixed-point execute stage with single-cycle add/sub/neg, a radix-2 iterative multiplier
// and a 1-entry skid buffer. Optional macro FX_CR0_UPDATE_EN adds CR0 flag outputs (cr0_o, cr0Valid_o).
//
// state | meaning
// IDLE  | accepting instructions; a full skid buffer is drained first
// MUL   | shift-add multiply in progress, busy_o high
module fx_exec_unit #(
  parameter logic [1:0]  FX_UNIT_CODE = 2'd0,
  parameter int unsigned MUL_ITERS    = 64
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [5:0]  opCode_i,
  input  logic [9:0]  xOpCode_i,
  input  logic        xOpCodeEnabled_i,
  input  logic [1:0]  functionalUnitCode_i,
  input  logic [63:0] operand1_i,
  input  logic [63:0] operand2_i,
  input  logic [63:0] operand3_i,
  input  logic        operand1Writeback_i,
  input  logic [4:0]  reg1Address_i,
  input  logic [15:0] imm_i,
  input  logic        immEnable_i,
  input  logic        bit2_i,
  input  logic        bit2Enable_i,
  input  logic [63:0] instructionAddress_i,
  output logic        busy_o,
  output logic        reg1isWriteback_o,
  output logic [4:0]  reg1WritebackAddress_o,
  output logic [63:0] reg1WritebackData_o,
  output logic [63:0] instructionAddress_o,
  output logic        illegal_o,
  output logic        overflow_o
`ifdef FX_CR0_UPDATE_EN
  ,
  output logic [0:3]  cr0_o,
  output logic        cr0Valid_o
`endif
);

  localparam logic [6:0] MUL_CNT = 7'(MUL_ITERS);

  typedef enum logic {IDLE, MUL} state_t;

  // xop keeps only the compared bits; the OE bit is dropped at capture.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [8:0]  xop;
    logic        xop_en;
    logic [1:0]  unit;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] op3;
    logic        wb;
    logic [4:0]  addr;
    logic [15:0] imm;
    logic [63:0] pc;
`ifdef FX_CR0_UPDATE_EN
    logic        rc;
`endif
  } instr_t;

  state_t      state_q;
  instr_t      buf_q;
  logic        buf_valid_q;
  logic [63:0] mul_a_q, mul_b_q, acc_q;
  logic [6:0]  cnt_q;
  logic        mul_wb_q;
  logic [4:0]  mul_addr_q;
  logic [63:0] mul_pc_q;
`ifdef FX_CR0_UPDATE_EN
  logic        mul_rc_q;
`endif

  instr_t      in_instr, cur;
  logic        cur_valid;
  logic [63:0] se;
  logic        legal_d, is_mul_d;
  logic [63:0] res_d, mul_a_d, mul_b_d, mul_step_d;
  logic        unused_inputs;

`ifdef FX_CR0_UPDATE_EN
  assign unused_inputs = ^{immEnable_i, xOpCode_i[9]};

  function automatic logic [0:3] cr0_of(input logic [63:0] v);
    cr0_of = {v[63], !v[63] && (v != 64'd0), v == 64'd0, 1'b0};
  endfunction
`else
  assign unused_inputs = ^{immEnable_i, xOpCode_i[9], bit2_i, bit2Enable_i};
`endif

  always_comb begin
    in_instr        = '0;
    in_instr.opcode = opCode_i;
    in_instr.xop    = xOpCode_i[8:0];
    in_instr.xop_en = xOpCodeEnabled_i;
    in_instr.unit   = functionalUnitCode_i;
    in_instr.op1    = operand1_i;
    in_instr.op2    = operand2_i;
    in_instr.op3    = operand3_i;
    in_instr.wb     = operand1Writeback_i;
    in_instr.addr   = reg1Address_i;
    in_instr.imm    = imm_i;
    in_instr.pc     = instructionAddress_i;
`ifdef FX_CR0_UPDATE_EN
    in_instr.rc     = bit2_i & bit2Enable_i;
`endif
  end

  // A buffered instruction always goes ahead of a new one.
  assign cur       = buf_valid_q ? buf_q : in_instr;
  assign cur_valid = buf_valid_q | enable_i;
  assign se        = {{48{cur.imm[15]}}, cur.imm};

  always_comb begin
    legal_d  = 1'b0;
    is_mul_d = 1'b0;
    res_d    = '0;
    mul_a_d  = '0;
    mul_b_d  = '0;
    if (cur.unit == FX_UNIT_CODE) begin
      case (cur.opcode)
        6'd14: begin legal_d = 1'b1; res_d = cur.op2 + se; end
        6'd15: begin legal_d = 1'b1; res_d = cur.op2 + (se << 16); end
        6'd7: begin
          legal_d  = 1'b1;
          is_mul_d = 1'b1;
          mul_a_d  = cur.op2;
          mul_b_d  = se;
        end
        6'd31: begin
          if (cur.xop_en) begin
            case (cur.xop)
              9'd266: begin legal_d = 1'b1; res_d = cur.op2 + cur.op3; end
              9'd40:  begin legal_d = 1'b1; res_d = cur.op3 - cur.op2; end
              9'd104: begin legal_d = 1'b1; res_d = 64'd0 - cur.op2; end
              9'd235: begin
                legal_d  = 1'b1;
                is_mul_d = 1'b1;
                mul_a_d  = {{32{cur.op2[31]}}, cur.op2[31:0]};
                mul_b_d  = {{32{cur.op3[31]}}, cur.op3[31:0]};
              end
              default: legal_d = 1'b0;
            endcase
          end
        end
        default: legal_d = 1'b0;
      endcase
    end
  end

  assign mul_step_d = acc_q + (mul_b_q[0] ? mul_a_q : 64'd0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q                <= IDLE;
      buf_q                  <= '0;
      buf_valid_q            <= 1'b0;
      mul_a_q                <= '0;
      mul_b_q                <= '0;
      acc_q                  <= '0;
      cnt_q                  <= '0;
      mul_wb_q               <= 1'b0;
      mul_addr_q             <= '0;
      mul_pc_q               <= '0;
      busy_o                 <= 1'b0;
      reg1isWriteback_o      <= 1'b0;
      reg1WritebackAddress_o <= '0;
      reg1WritebackData_o    <= '0;
      instructionAddress_o   <= '0;
      illegal_o              <= 1'b0;
      overflow_o             <= 1'b0;
`ifdef FX_CR0_UPDATE_EN
      mul_rc_q               <= 1'b0;
      cr0_o                  <= '0;
      cr0Valid_o             <= 1'b0;
`endif
    end else begin
      reg1isWriteback_o <= 1'b0;
      illegal_o         <= 1'b0;
`ifdef FX_CR0_UPDATE_EN
      cr0Valid_o        <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (buf_valid_q) begin
            buf_valid_q <= enable_i;
            if (enable_i) buf_q <= in_instr;
          end
          if (cur_valid) begin
            if (!legal_d) begin
              // Illegal ops still write op1 back so the pending flag upstream clears.
              illegal_o            <= 1'b1;
              instructionAddress_o <= cur.pc;
              if (cur.wb) begin
                reg1isWriteback_o      <= 1'b1;
                reg1WritebackAddress_o <= cur.addr;
                reg1WritebackData_o    <= cur.op1;
              end
            end else if (is_mul_d) begin
              state_q    <= MUL;
              busy_o     <= 1'b1;
              mul_a_q    <= mul_a_d;
              mul_b_q    <= mul_b_d;
              acc_q      <= '0;
              cnt_q      <= MUL_CNT;
              mul_wb_q   <= cur.wb;
              mul_addr_q <= cur.addr;
              mul_pc_q   <= cur.pc;
`ifdef FX_CR0_UPDATE_EN
              mul_rc_q   <= cur.rc;
`endif
            end else if (cur.wb) begin
              reg1isWriteback_o      <= 1'b1;
              reg1WritebackAddress_o <= cur.addr;
              reg1WritebackData_o    <= res_d;
              instructionAddress_o   <= cur.pc;
`ifdef FX_CR0_UPDATE_EN
              cr0Valid_o             <= cur.rc;
              cr0_o                  <= cr0_of(res_d);
`endif
            end
          end
        end
        MUL: begin
          if (enable_i) begin
            if (buf_valid_q) begin
              overflow_o <= 1'b1;
            end else begin
              buf_q       <= in_instr;
              buf_valid_q <= 1'b1;
            end
          end
          acc_q   <= mul_step_d;
          mul_a_q <= mul_a_q << 1;
          mul_b_q <= mul_b_q >> 1;
          cnt_q   <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            if (mul_wb_q) begin
              reg1isWriteback_o      <= 1'b1;
              reg1WritebackAddress_o <= mul_addr_q;
              reg1WritebackData_o    <= mul_step_d;
              instructionAddress_o   <= mul_pc_q;
`ifdef FX_CR0_UPDATE_EN
              cr0Valid_o             <= mul_rc_q;
              cr0_o                  <= cr0_of(mul_step_d);
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
